// File: rtl/pc_tx_pkg.sv
// pc_tx_pkg: state encoding, framing constants and byte-order helpers shared by the PC_TX word serialiser.
package pc_tx_pkg;
    typedef enum logic [1:0] {sIDLE = 2'd0, sSEND = 2'd1, sMARKER = 2'd2} state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam logic [7:0] FRAME_MARKER = 8'hA5;
    function automatic logic [7:0] lead_byte(input logic [31:0] word, input bit msb_first);
        return msb_first ? word[31:24] : word[7:0];
    endfunction
    function automatic logic [31:0] shift_word(input logic [31:0] word, input bit msb_first);
        return msb_first ? {word[23:0], 8'h00} : {8'h00, word[31:8]};
    endfunction
endpackage

// File: rtl/pc_tx_word_fifo.sv
// pc_tx_word_fifo: synchronous word FIFO; the extra pointer bit separates full from empty.
module pc_tx_word_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_write,
    input  logic [31:0] i_wdata,
    input  logic        i_pop,
    output logic [31:0] o_rdata,
    output logic        o_full,
    output logic        o_empty
);
    logic [DEPTH_LOG2:0] r_wptr;
    logic [DEPTH_LOG2:0] r_rptr;
    logic [31:0]         r_mem [2**DEPTH_LOG2];
    logic                w_write;
    logic                w_pop;
    assign o_empty = r_wptr == r_rptr;
    assign o_full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                     (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
    assign w_write = i_write && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rptr[DEPTH_LOG2-1:0]];
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_wptr <= r_wptr + (DEPTH_LOG2+1)'(w_write);
            r_rptr <= r_rptr + (DEPTH_LOG2+1)'(w_pop);
        end
    end
    always_ff @(posedge i_clock) begin
        if (w_write) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= i_wdata;
    end
endmodule

// File: rtl/pc_tx_word_serialiser.sv
// pc_tx_word_serialiser: buffers router words and streams them as bytes over valid/ready.
// Define PC_TX_FRAME_MARKER_EN to prefix every word with the FRAME_MARKER byte.
module pc_tx_word_serialiser
    import pc_tx_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [31:0] i_word,
    input  logic        i_word_valid,
    output logic        o_busy,
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    input  logic        i_byte_ready,
    output logic        o_overflow,
    output logic        o_idle
);
    state_t      r_state;
    logic [31:0] r_shift;
    logic [1:0]  r_idx;
    logic [7:0]  r_byte;
    logic        r_byte_valid;
    logic        r_overflow;
    logic [31:0] w_head;
    logic [31:0] w_next_shift;
    logic        w_full;
    logic        w_empty;
    logic        w_fire;
    logic        w_last;
    logic        w_pop;
    assign w_fire       = r_byte_valid && i_byte_ready;
    assign w_last       = w_fire && r_state == sSEND && r_idx == 2'(BYTES_PER_WORD - 1);
    // Reloading on the last transfer keeps consecutive words bubble-free.
    assign w_pop        = !w_empty && (r_state == sIDLE || w_last);
    assign w_next_shift = shift_word(r_shift, MSB_FIRST);
    assign o_busy       = w_full;
    assign o_byte       = r_byte;
    assign o_byte_valid = r_byte_valid;
    assign o_overflow   = r_overflow;
    assign o_idle       = r_state == sIDLE && w_empty;
    pc_tx_word_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_write   (i_word_valid),
        .i_wdata   (i_word),
        .i_pop     (w_pop),
        .o_rdata   (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= sIDLE;
            r_shift      <= '0;
            r_idx        <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (i_word_valid && w_full) r_overflow <= 1'b1;
            if (w_pop) begin
                r_shift      <= w_head;
                r_idx        <= '0;
                r_byte_valid <= 1'b1;
`ifdef PC_TX_FRAME_MARKER_EN
                r_state      <= sMARKER;
                r_byte       <= FRAME_MARKER;
`else
                r_state      <= sSEND;
                r_byte       <= lead_byte(w_head, MSB_FIRST);
`endif
            end else if (w_last) begin
                r_state      <= sIDLE;
                r_byte_valid <= 1'b0;
`ifdef PC_TX_FRAME_MARKER_EN
            end else if (w_fire && r_state == sMARKER) begin
                r_state      <= sSEND;
                r_byte       <= lead_byte(r_shift, MSB_FIRST);
`endif
            end else if (w_fire) begin
                r_idx        <= r_idx + 2'd1;
                r_shift      <= w_next_shift;
                r_byte       <= lead_byte(w_next_shift, MSB_FIRST);
            end
        end
    end
endmodule

// File: doc/pc_tx_word_serialiser.md
Name: pc_tx_word_serialiser

Overview:
- Downstream neighbour of the data router on the PC_TX path.
- Accepts 32-bit words (pulse-qualified) into a small word buffer.
- Breaks each word into bytes and hands them to the PC byte transmitter (UART/USB byte interface) over a valid/ready handshake.
- Drives the busy indication the router samples before issuing the next word.

Parameters:
- DEPTH_LOG2, 2, log2 of word-buffer depth (default 4 words); legal 1..4.
- MSB_FIRST, 1, 1 = byte[31:24] sent first; 0 = byte[7:0] sent first.

Ports:
- i_clock  input  1  system clock, all logic on posedge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_word  input  32  data word from router.
- i_word_valid  input  1  one-cycle write strobe for i_word.
- o_busy  output  1  high when word buffer full; router must not strobe.
- o_byte  output  8  byte to transmitter.
- o_byte_valid  output  1  o_byte holds a valid byte.
- i_byte_ready  input  1  transmitter accepts o_byte this cycle.
- o_overflow  output  1  sticky: a word strobed while full was dropped.
- o_idle  output  1  buffer empty and no byte in flight.

Behaviour:
- Reset:
  - Reset is async assert, sync release.
  - All outputs reset low: o_byte=0x00, o_byte_valid=0, o_busy=0, o_overflow=0. Exception: o_idle=1.
  - Buffer pointers cleared; FSM goes to sIDLE.
- Word buffer:
  - Synchronous FIFO, 2^DEPTH_LOG2 words; pointers are DEPTH_LOG2+1 bits for the full/empty distinction.
  - Write when i_word_valid && !full.
  - Write while full: word dropped, o_overflow set, held until reset.
  - o_busy = full, registered, so it reflects the state after this cycle's write/pop.
  - Simultaneous write and pop when full: write rejected (full is evaluated before the pop).
  - Simultaneous write and pop when not full: both occur; count unchanged.
- Transfer rule: a byte moves when o_byte_valid && i_byte_ready. o_byte and o_byte_valid stay stable until accepted.
- FSM states:
  - sIDLE: o_byte_valid=0. If buffer not empty: pop the head word into a 32-bit shift register, set byte index=0, go to sSEND.
  - sSEND: o_byte_valid=1, o_byte = current byte per MSB_FIRST. On transfer:
    - If index<3: index++ and shift, stay in sSEND.
    - If index==3 and buffer not empty: pop the next word and reload, index=0, stay in sSEND. This gives back-to-back bytes with no bubble.
    - If index==3 and buffer empty: go to sIDLE.
- Latency:
  - Word strobed at cycle N into an empty, idle block: o_byte_valid rises at N+2 (FIFO write at N, pop/load at N+1).
  - With i_byte_ready held high, four bytes are accepted on consecutive cycles N+2..N+5.
- o_idle = (state==sIDLE) && empty.
- i_byte_ready low while in sIDLE has no effect.
- Reset asserted mid-word: the partial word and all buffered words are discarded; no further bytes are emitted.

Optional Feature:
- Macro: PC_TX_FRAME_MARKER_EN.
- Defined:
  - Each word is preceded by the marker byte 0xA5, giving 5 bytes per word.
  - An added sMARKER state is entered from the pop: marker transfer → sSEND at index 0.
  - After the last byte, if the buffer is not empty, the FSM goes to sMARKER.
  - Latency to the first data byte grows by one transfer.
- Undefined: no marker, 4 bytes per word; sMARKER is not synthesised.

Decomposition:
- Package pc_tx_pkg:
  - State encoding localparams sIDLE/sSEND/sMARKER (2 bits).
  - BYTES_PER_WORD=4.
  - FRAME_MARKER=8'hA5.
- Sub-module pc_tx_word_fifo: parameterised sync FIFO (write, pop, data out, full, empty, async active-low reset). Instantiated once.
- FSM, shift register and byte index live in the top module.

Test Plan:
- Reset check: assert i_reset_n=0 mid-operation → all outputs at reset values the same cycle; o_idle=1 after release.
- Single word:
  - Write 0x11223344, i_byte_ready=1, MSB_FIRST=1 → bytes 0x11,0x22,0x33,0x44 at N+2..N+5.
  - Then o_idle=1.
  - With MSB_FIRST=0 → 0x44,0x33,0x22,0x11.
- Backpressure:
  - Toggle i_byte_ready 1-0-1-0 on word 0xDEADBEEF → each byte is held stable while ready is low.
  - Exactly 4 transfers, no duplicates.
- Full/overflow:
  - DEPTH_LOG2=2, i_byte_ready=0, strobe 6 words → 1 word is loaded into the shift register and 4 fill the buffer.
  - o_busy=1 after the 5th; the 6th is dropped and o_overflow=1.
  - Release ready → exactly 20 bytes out, in order.
- Back-to-back: 3 words queued, ready=1 → 12 bytes on 12 consecutive cycles with no gap between words.
- With PC_TX_FRAME_MARKER_EN: write 0x01020304 → 0xA5,0x01,0x02,0x03,0x04.
